// File: rtl/step_sequencer_ctrl_pkg.sv
// Shared definitions for the step sequencer: state encoding and dwell-range check.
package step_sequencer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    // A dwell must be at least one cycle and fit the counter without wrapping.
    function automatic bit dwell_ok(input int dwell, input int cw);
        return (dwell >= 1) && (dwell <= ((1 << cw) - 1));
    endfunction

endpackage

// File: rtl/step_sequencer_ctrl_rise_detect.sv
// Rising-edge detector for push-button/request levels; a level held through reset
// is not reported as an edge because the history register resets high.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_a_q;

    always_ff @(posedge clk) begin
        if (reset) r_a_q <= 1'b1;
        else       r_a_q <= d;
    end

    assign rise = d & ~r_a_q;

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Three-step output sequencer: a rising edge on A runs IDLE->S1->S2->S3->IDLE,
// with one extra request queued and replayed back-to-back.
module step_sequencer_ctrl
    import step_sequencer_ctrl_pkg::*;
#(
    parameter int DWELL1 = 2,
    parameter int DWELL2 = 3,
    parameter int DWELL3 = 4,
    parameter int CW     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic A,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic busy,
    output logic done
);

    if (!dwell_ok(DWELL1, CW) || !dwell_ok(DWELL2, CW) || !dwell_ok(DWELL3, CW)) begin : g_bad_dwell
        $error("step_sequencer_ctrl: dwell out of range for counter width");
    end

    localparam logic [CW-1:0] LAST1 = CW'(DWELL1 - 1);
    localparam logic [CW-1:0] LAST2 = CW'(DWELL2 - 1);
    localparam logic [CW-1:0] LAST3 = CW'(DWELL3 - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          r_done;
    logic          w_rise;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (A),
        .rise  (w_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= S1;
                        r_cnt   <= '0;
                    end
                end
                S1: begin
                    if (w_rise) r_pend <= 1'b1;
                    if (r_cnt == LAST1) begin
                        r_cnt   <= '0;
                        r_state <= S2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S2: begin
                    if (w_rise) r_pend <= 1'b1;
                    if (r_cnt == LAST2) begin
                        r_cnt   <= '0;
                        r_state <= S3;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S3: begin
                    if (r_cnt == LAST3) begin
                        // A request arriving in the exit cycle restarts directly, same as a queued one.
                        r_cnt  <= '0;
                        r_done <= 1'b1;
                        r_pend <= 1'b0;
                        if (r_pend || w_rise) r_state <= S1;
                        else                  r_state <= IDLE;
                    end else begin
                        if (w_rise) r_pend <= 1'b1;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Y1   = (r_state == S1);
    assign Y2   = (r_state == S2);
    assign Y3   = (r_state == S3);
    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule
